// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider controller.
package clk_div_pkg;

  localparam int SEL_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // A select is usable only if it names an existing counter bit.
  function automatic logic sel_valid(input int sel, input int cntW);
    return (sel >= 32'sd0) && (sel < cntW);
  endfunction

endpackage

// File: rtl/clk_div_tap.sv
// Free-running divider counter with selectable tap, period-boundary detect and
// registered divided output / rising-edge tick.
module clk_div_tap #(
  parameter int CNT_W = 5,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [SEL_W-1:0] sel,
  output logic             divOut,
  output logic             divTick,
  output logic             bnd
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [CNT_W-1:0] tapBit;
  logic [CNT_W-1:0] periodMask;
  logic             nextDiv;

  assign cntNext    = cnt + ONE;
  assign tapBit     = ONE << sel;
  // Bits [sel:0]; for the widest select the shift overflows to zero and the mask becomes all ones.
  assign periodMask = (tapBit << 1'b1) - ONE;
  assign bnd        = ((cnt & periodMask) == periodMask);
  assign nextDiv    = |(cntNext & tapBit);

  // Counter and output registers; clear restarts a full period from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= {CNT_W{1'b0}};
      divOut  <= 1'b0;
      divTick <= 1'b0;
    end else if (clear) begin
      cnt     <= {CNT_W{1'b0}};
      divOut  <= 1'b0;
      divTick <= 1'b0;
    end else if (run) begin
      cnt     <= cntNext;
      divOut  <= nextDiv;
      divTick <= nextDiv & ~divOut;
    end else begin
      divTick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Glitch-free programmable clock divider: ratio FSM and req/ack handshake around
// a single tap counter; ratio changes and stops land only on period boundaries.
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 5,
  parameter int DEF_SEL = 0,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sel_req,
  input  logic [SEL_W-1:0] sel_data,
  output logic             sel_ack,
  output logic             sel_err,
  output logic [SEL_W-1:0] cur_sel,
  output logic             div_out,
  output logic             div_tick,
  output logic             busy
);
  state_t           state, nextState;
  logic [SEL_W-1:0] curSel, nextCurSel, pendSel, nextPendSel, reqSel;
  logic             pending, nextPending, selAckQ, nextAck, selErrQ, nextErr;
  logic             accept, reqValid, takeNew, badReq, haveReq;
  logic             bnd, tapClear, tapRun;

  // The cycle after an ack the requester may still hold sel_req; selAckQ masks it.
  assign accept   = sel_req & ~pending & ~selAckQ;
  assign reqValid = sel_valid(int'(sel_data), CNT_W);
  assign takeNew  = accept & reqValid;
  assign badReq   = accept & ~reqValid;
  assign haveReq  = pending | takeNew;
  assign reqSel   = pending ? pendSel : sel_data;
  assign tapRun   = (state != IDLE);

  // Next-state, handshake and counter-clear decisions.
  always_comb begin
    nextState   = state;
    nextCurSel  = curSel;
    nextPendSel = pendSel;
    nextPending = pending;
    nextAck     = badReq;
    nextErr     = badReq;
    tapClear    = 1'b0;
    case (state)
      IDLE: begin
        nextCurSel = takeNew ? sel_data : curSel;
        nextAck    = takeNew | badReq;
        nextState  = en ? RUN : IDLE;
      end
      RUN, PEND, DRAIN: begin
        if (bnd) begin
          nextCurSel  = haveReq ? reqSel : curSel;
          nextAck     = haveReq | badReq;
          nextPending = 1'b0;
          tapClear    = haveReq | (state == DRAIN);
          if (state == DRAIN) begin
            nextState = IDLE;
          end else begin
            nextState = en ? RUN : DRAIN;
          end
        end else begin
          nextPending = haveReq;
          nextPendSel = takeNew ? sel_data : pendSel;
          if (state == RUN) begin
            nextState = en ? (takeNew ? PEND : RUN) : DRAIN;
          end else begin
            nextState = state;
          end
        end
      end
      default: begin
        nextState   = IDLE;
        nextPending = 1'b0;
      end
    endcase
  end

  // Controller state and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      curSel  <= SEL_W'(DEF_SEL);
      pendSel <= {SEL_W{1'b0}};
      pending <= 1'b0;
      selAckQ <= 1'b0;
      selErrQ <= 1'b0;
    end else begin
      state   <= nextState;
      curSel  <= nextCurSel;
      pendSel <= nextPendSel;
      pending <= nextPending;
      selAckQ <= nextAck;
      selErrQ <= nextErr;
    end
  end

  clk_div_tap #(
    .CNT_W(CNT_W),
    .SEL_W(SEL_W)
  ) uTap (
    .clk    (clk),
    .rst    (rst),
    .run    (tapRun),
    .clear  (tapClear),
    .sel    (curSel),
    .divOut (div_out),
    .divTick(div_tick),
    .bnd    (bnd)
  );

  assign sel_ack = selAckQ;
  assign sel_err = selErrQ;
  assign cur_sel = curSel;
  assign busy    = (state == PEND) | (state == DRAIN) | pending;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Self-checking bench: directed scenarios plus random requests, each cycle compared
// against a period/phase reference model of the divider.
module tb_clk_div_ratio_ctrl;
  localparam int CNT_W   = 5;
  localparam int DEF_SEL = 0;
  localparam int SEL_W   = 3;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             en       = 1'b0;
  logic             sel_req  = 1'b0;
  logic [SEL_W-1:0] sel_data = 3'd0;
  logic             sel_ack, sel_err, div_out, div_tick, busy;
  logic [SEL_W-1:0] cur_sel;

  int checks   = 0;
  int failures = 0;

  // Reference model: counting flag, stop flag, one-deep pending slot, position in period.
  bit mActive, mStopping, mPend, mDiv, mTick, mAck, mErr;
  int mSel, mPendSel, mPos;

  int  lat, lowRun, highRun, ticks, acks, highMore;
  bit  got;

  clk_div_ratio_ctrl #(.CNT_W(CNT_W), .DEF_SEL(DEF_SEL), .SEL_W(SEL_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sel_req (sel_req),
    .sel_data(sel_data),
    .sel_ack (sel_ack),
    .sel_err (sel_err),
    .cur_sel (cur_sel),
    .div_out (div_out),
    .div_tick(div_tick),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    mActive = 0; mStopping = 0; mPend = 0; mDiv = 0; mTick = 0; mAck = 0; mErr = 0;
    mSel = DEF_SEL; mPendSel = 0; mPos = 0;
  endtask

  task automatic modelEdge();
    int p, d, rsel;
    bit last, acc, ok, take, bad, have, clr, wasActive, wasPend, nd;
    p = 1 << (mSel + 1);
    d = int'(sel_data);
    wasActive = mActive;
    wasPend = mPend;
    last = mActive && ((mPos % p) == p - 1);
    acc = sel_req && !mPend && !mAck;
    ok = d < CNT_W;
    take = acc && ok;
    bad = acc && !ok;
    have = mPend || take;
    rsel = mPend ? mPendSel : d;
    mAck = bad; mErr = bad; clr = 0;
    if (!mActive) begin
      if (take) begin mSel = d; mAck = 1; end
      if (en) mActive = 1;
    end else if (last) begin
      if (have) begin mSel = rsel; mAck = 1; mPend = 0; clr = 1; end
      if (mStopping) begin mActive = 0; mStopping = 0; clr = 1; end
      else if (!en) mStopping = 1;
    end else begin
      if (take) begin mPend = 1; mPendSel = d; end
      if (!en && !wasPend) mStopping = 1;
    end
    if (clr) begin
      mPos = 0; mDiv = 0; mTick = 0;
    end else if (wasActive) begin
      mPos++;
      p = 1 << (mSel + 1);
      nd = (mPos % p) >= (p / 2);
      mTick = nd && !mDiv;
      mDiv = nd;
    end else begin
      mTick = 0;
    end
  endtask

  task automatic checkOutputs();
    chk("div_out",  32'(div_out),  32'(mDiv));
    chk("div_tick", 32'(div_tick), 32'(mTick));
    chk("sel_ack",  32'(sel_ack),  32'(mAck));
    chk("sel_err",  32'(sel_err),  32'(mErr));
    chk("cur_sel",  32'(cur_sel),  32'(mSel));
    chk("busy",     32'(busy),     32'(mStopping || mPend));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) modelReset();
    else modelEdge();
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic doReq(input int d, output int latency);
    bit seen;
    seen = 0; latency = 0;
    sel_req = 1'b1; sel_data = SEL_W'(d);
    for (int i = 0; i < 200 && !seen; i++) begin
      cycle(); latency++; seen = sel_ack;
    end
    sel_req = 1'b0;
    chk("reqAckSeen", 32'(seen), 32'd1);
  endtask

  initial begin
    modelReset();
    // Reset, then /2 run
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    en = 1'b1;
    cycle();
    ticks = 0;
    for (int i = 0; i < 100; i++) begin cycle(); ticks += int'(div_tick); end
    chk("ticksIn100", 32'(ticks), 32'd50);

    // /4 then /32 requested one cycle after a boundary
    doReq(1, lat);
    cycle();
    for (int i = 0; i < 8 && (mPos % 4) != 0; i++) cycle();
    sel_req = 1'b1; sel_data = 3'd4;
    got = 0; lat = 0;
    for (int i = 0; i < 50 && !got; i++) begin cycle(); lat++; got = sel_ack; end
    sel_req = 1'b0;
    chk("switchAckSeen", 32'(got), 32'd1);
    chk("switchEdgesAfterAccept", 32'(lat - 1), 32'd3);
    lowRun = 0;
    for (int i = 0; i < 100 && div_out == 1'b0; i++) begin lowRun++; cycle(); end
    highRun = 0;
    for (int i = 0; i < 100 && div_out == 1'b1; i++) begin highRun++; cycle(); end
    chk("lowPhase32", 32'(lowRun), 32'd16);
    chk("highPhase32", 32'(highRun), 32'd16);

    // Invalid select
    sel_req = 1'b1; sel_data = 3'd5;
    cycle();
    sel_req = 1'b0;
    chk("invalidAck", 32'(sel_ack), 32'd1);
    chk("invalidErr", 32'(sel_err), 32'd1);
    chk("invalidKeepsSel", 32'(cur_sel), 32'd4);
    for (int i = 0; i < 100 && div_out == 1'b0; i++) cycle();
    highRun = 0;
    for (int i = 0; i < 100 && div_out == 1'b1; i++) begin highRun++; cycle(); end
    chk("highAfterInvalid", 32'(highRun), 32'd16);

    // Stop two cycles into a /16 high phase
    doReq(3, lat);
    for (int i = 0; i < 100 && div_out == 1'b0; i++) cycle();
    cycle();
    en = 1'b0;
    highMore = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (div_out) highMore++;
      else break;
    end
    chk("stopHighRemaining", 32'(highMore), 32'd6);
    chk("stopBusyDrop", 32'(busy), 32'd0);
    cycle(); cycle();
    chk("stopStaysLow", 32'(div_out), 32'd0);

    // Request held past its ack
    en = 1'b1; sel_req = 1'b1; sel_data = 3'd2;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin cycle(); got = sel_ack; end
    chk("heldReqFirstAck", 32'(got), 32'd1);
    acks = 0;
    for (int i = 0; i < 3; i++) begin cycle(); acks += int'(sel_ack); end
    chk("heldReqNoExtraAck", 32'(acks), 32'd0);
    chk("heldReqReaccepted", 32'(busy), 32'd1);
    sel_req = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin cycle(); got = sel_ack; end
    chk("heldReqSecondAck", 32'(got), 32'd1);

    // Random requests and enable toggles
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      if (!sel_req && $urandom_range(0, 9) == 0) begin
        sel_req = 1'b1;
        sel_data = SEL_W'($urandom_range(0, 7));
      end
      cycle();
      if (sel_req && mAck) sel_req = 1'b0;
    end
    sel_req = 1'b0;

    // Asynchronous reset while div_out is high
    en = 1'b1;
    cycle(); cycle();
    doReq(2, lat);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin cycle(); got = div_out; end
    chk("preResetDivHigh", 32'(got), 32'd1);
    #2 rst = 1'b1;
    modelReset();
    #1;
    chk("rstAsyncDiv", 32'(div_out), 32'd0);
    chk("rstAsyncCurSel", 32'(cur_sel), 32'(DEF_SEL));
    checkOutputs();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
